// File: rtl/rstl_max_reader.sv
// Reads the result memory in address triples over three parallel ports and
// streams the packed triples out through a 2-entry FIFO with ready/valid handshake.
module rstl_max_reader #(
  parameter int counterWidth     = 10,
  parameter int numWeightRstlMax = 507,
  parameter int dataWidth        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [counterWidth-1:0]   addr_1,
  output logic [counterWidth-1:0]   addr_2,
  output logic [counterWidth-1:0]   addr_3,
  output logic                      rd_en,
  input  logic [dataWidth-1:0]      rd_data_1,
  input  logic [dataWidth-1:0]      rd_data_2,
  input  logic [dataWidth-1:0]      rd_data_3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3*dataWidth-1:0]    out_data,
  output logic                      busy,
  output logic                      done
);

  localparam int TW = 3 * dataWidth;
  localparam logic [counterWidth-1:0] LAST_ADDR = counterWidth'(numWeightRstlMax - 1);
  localparam logic [counterWidth-1:0] STEP      = counterWidth'(3);
  localparam logic [counterWidth-1:0] ADDR1_INIT = counterWidth'(0);
  localparam logic [counterWidth-1:0] ADDR2_INIT = counterWidth'(1);
  localparam logic [counterWidth-1:0] ADDR3_INIT = counterWidth'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [counterWidth-1:0]   addr1_q, addr1_d;
  logic [counterWidth-1:0]   addr2_q, addr2_d;
  logic [counterWidth-1:0]   addr3_q, addr3_d;
  logic                      inflight_q, inflight_d;
  logic [TW-1:0]             fifo0_q, fifo0_d;
  logic [TW-1:0]             fifo1_q, fifo1_d;
  logic                      wptr_q, wptr_d;
  logic                      rptr_q, rptr_d;
  logic [1:0]                count_q, count_d;

  logic [TW-1:0]             landing_s;
  logic [TW-1:0]             head_s;
  logic                      pop_s;
  logic                      store_push_s;
  logic                      store_pop_s;
  logic [2:0]                occ_after_pop_s;
  logic                      rd_en_s;

  // Output side: a triple landing this cycle is already visible at the head,
  // so it can be handed out in the same cycle it returns from memory.
  always_comb begin
    landing_s = {rd_data_3, rd_data_2, rd_data_1};
    if (count_q != 2'd0) begin
      head_s = rptr_q ? fifo1_q : fifo0_q;
    end else if (inflight_q) begin
      head_s = landing_s;
    end else begin
      head_s = '0;
    end
    out_valid       = (count_q != 2'd0) || inflight_q;
    out_data        = head_s;
    pop_s           = out_valid && out_ready;
    occ_after_pop_s = 3'(count_q) + 3'(inflight_q) - 3'(pop_s);
    rd_en_s         = (state_q == RUN) && (occ_after_pop_s < 3'd2);
    rd_en           = rd_en_s;
    addr_1          = addr1_q;
    addr_2          = addr2_q;
    addr_3          = addr3_q;
    busy            = (state_q == RUN) || (state_q == DRAIN);
    done            = (state_q == DONE);
  end

  // Storage update: a landing triple consumed directly is never stored.
  always_comb begin
    store_pop_s  = pop_s && (count_q != 2'd0);
    store_push_s = inflight_q && !(pop_s && (count_q == 2'd0));
    fifo0_d      = fifo0_q;
    fifo1_d      = fifo1_q;
    if (store_push_s) begin
      if (wptr_q) begin
        fifo1_d = landing_s;
      end else begin
        fifo0_d = landing_s;
      end
    end else begin
      fifo0_d = fifo0_q;
    end
    wptr_d     = wptr_q ^ store_push_s;
    rptr_d     = rptr_q ^ store_pop_s;
    count_d    = count_q + 2'(store_push_s) - 2'(store_pop_s);
    inflight_d = rd_en_s;
  end

  // Pass sequencing and read-address generation.
  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    addr3_d = addr3_q;
    case (state_q)
      IDLE: begin
        addr1_d = ADDR1_INIT;
        addr2_d = ADDR2_INIT;
        addr3_d = ADDR3_INIT;
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rd_en_s) begin
          addr1_d = addr1_q + STEP;
          addr2_d = addr2_q + STEP;
          addr3_d = addr3_q + STEP;
          if (addr3_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (occ_after_pop_s == 3'd0) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr1_d = ADDR1_INIT;
        addr2_d = ADDR2_INIT;
        addr3_d = ADDR3_INIT;
      end
      default: begin
        state_d = IDLE;
        addr1_d = ADDR1_INIT;
        addr2_d = ADDR2_INIT;
        addr3_d = ADDR3_INIT;
      end
    endcase
  end

  // State register; reset drops buffered and in-flight data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr1_q    <= ADDR1_INIT;
      addr2_q    <= ADDR2_INIT;
      addr3_q    <= ADDR3_INIT;
      inflight_q <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr3_q    <= addr3_d;
      inflight_q <= inflight_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_rstl_max_reader.sv
// Randomized bench for rstl_max_reader: a triple-list reference built from the
// memory image is compared against every transfer, plus latency and protocol checks.
module tb_rstl_max_reader;

  localparam int CW = 10;
  localparam int N  = 507;
  localparam int DW = 8;
  localparam int NT = N / 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_s, start_s, out_ready_s, rd_en_s, out_valid_s, busy_s, done_s;
  logic [CW-1:0]   addr1_s, addr2_s, addr3_s;
  logic [DW-1:0]   rd1_s, rd2_s, rd3_s;
  logic [3*DW-1:0] out_data_s;

  logic            start3_s, ready3_s, rd_en3_s, valid3_s, busy3_s, done3_s;
  logic [CW-1:0]   a31_s, a32_s, a33_s;
  logic [DW-1:0]   r31_s, r32_s, r33_s;
  logic [3*DW-1:0] data3_s;

  logic [DW-1:0]   mem [1024];
  logic [3*DW-1:0] exp_t [NT];

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt, out_cnt, done_cnt, cyc;
  logic stall_prev;
  logic [3*DW-1:0] prev_data;

  rstl_max_reader #(.counterWidth(CW), .numWeightRstlMax(N), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst_s), .start(start_s),
    .addr_1(addr1_s), .addr_2(addr2_s), .addr_3(addr3_s), .rd_en(rd_en_s),
    .rd_data_1(rd1_s), .rd_data_2(rd2_s), .rd_data_3(rd3_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
    .busy(busy_s), .done(done_s)
  );

  rstl_max_reader #(.counterWidth(CW), .numWeightRstlMax(3), .dataWidth(DW)) dut3 (
    .clk(clk), .rst(rst_s), .start(start3_s),
    .addr_1(a31_s), .addr_2(a32_s), .addr_3(a33_s), .rd_en(rd_en3_s),
    .rd_data_1(r31_s), .rd_data_2(r32_s), .rd_data_3(r33_s),
    .out_valid(valid3_s), .out_ready(ready3_s), .out_data(data3_s),
    .busy(busy3_s), .done(done3_s)
  );

  // Synchronous-read memory: data returns the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en_s) begin
      rd1_s <= mem[addr1_s];
      rd2_s <= mem[addr2_s];
      rd3_s <= mem[addr3_s];
    end
    if (rd_en3_s) begin
      r31_s <= mem[a31_s];
      r32_s <= mem[a32_s];
      r33_s <= mem[a33_s];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic build_exp();
    for (int k = 0; k < NT; k++) begin
      exp_t[k] = {mem[3*k+2], mem[3*k+1], mem[3*k]};
    end
  endtask

  // Per-cycle observation of the main instance, called after inputs settle.
  task automatic observe();
    if (rd_en_s) begin
      check("rd_addr_1", 32'(addr1_s), 32'(3*rd_cnt));
      check("rd_addr_2", 32'(addr2_s), 32'(3*rd_cnt+1));
      check("rd_addr_3", 32'(addr3_s), 32'(3*rd_cnt+2));
      check("rd_addr_range", 32'(addr3_s <= CW'(N-1)), 32'd1);
      rd_cnt++;
    end
    if (stall_prev) begin
      check("stall_valid", 32'(out_valid_s), 32'd1);
      check("stall_data", 32'(out_data_s), 32'(prev_data));
    end
    if (out_valid_s && out_ready_s) begin
      if (out_cnt < NT) check("out_data", 32'(out_data_s), 32'(exp_t[out_cnt]));
      else check("extra_triple", 32'(out_cnt), 32'(NT-1));
      out_cnt++;
    end else if (!out_valid_s) begin
      check("empty_out_data", 32'(out_data_s), 32'd0);
    end
    check("occupancy", 32'((rd_cnt - out_cnt) <= 2), 32'd1);
    check("busy_done_excl", 32'(busy_s & done_s), 32'd0);
    if (done_s) begin
      check("done_all_out", 32'(out_cnt), 32'(NT));
      done_cnt++;
    end
    stall_prev = out_valid_s && !out_ready_s;
    prev_data  = out_data_s;
  endtask

  // mode 0: ready=1, 1: 10-cycle stall at first out_valid, 2: random ready, 3: start re-pulsed
  task automatic run_pass(input int mode, input int exp_done);
    int first_rd, first_ov, done_at;
    first_rd = -1; first_ov = -1; done_at = -1;
    rd_cnt = 0; out_cnt = 0; done_cnt = 0; stall_prev = 1'b0;
    cyc = 0;
    start_s = 1'b1;
    out_ready_s = 1'b1;
    #1;
    check("idle_rd_en", 32'(rd_en_s), 32'd0);
    while (cyc < 3000 && (done_at < 0 || cyc < done_at + 3)) begin
      @(posedge clk); #1;
      cyc++;
      start_s = (mode == 3) && (cyc == 5 || cyc == 60);
      case (mode)
        1:       out_ready_s = !(cyc >= 2 && cyc < 12);
        2:       out_ready_s = 1'($urandom_range(0, 1));
        default: out_ready_s = 1'b1;
      endcase
      #1;
      if (cyc == 1) check("busy_after_start", 32'(busy_s), 32'd1);
      if (mode == 1 && cyc == 11) begin
        check("bp_rd_en", 32'(rd_en_s), 32'd0);
        check("bp_buffered", 32'(rd_cnt - out_cnt), 32'd2);
        check("bp_valid", 32'(out_valid_s), 32'd1);
        check("bp_head", 32'(out_data_s), 32'(exp_t[0]));
      end
      if (rd_en_s && first_rd < 0) first_rd = cyc;
      if (out_valid_s && first_ov < 0) first_ov = cyc;
      if (done_s && done_at < 0) done_at = cyc;
      observe();
    end
    check("triples_out", 32'(out_cnt), 32'(NT));
    check("reads_issued", 32'(rd_cnt), 32'(NT));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after_done", 32'(busy_s), 32'd0);
    if (mode != 2) begin
      check("first_rd_en", 32'(first_rd), 32'd1);
      check("first_out_valid", 32'(first_ov), 32'd2);
    end
    if (exp_done > 0) check("done_cycle", 32'(done_at), 32'(exp_done));
  endtask

  task automatic reset_mid_pass();
    rd_cnt = 0; out_cnt = 0; done_cnt = 0; stall_prev = 1'b0; cyc = 0;
    start_s = 1'b1;
    out_ready_s = 1'b1;
    while (cyc < 500 && out_cnt < 50) begin
      @(posedge clk); #1;
      cyc++;
      start_s = 1'b0;
      #1;
      observe();
    end
    check("reached_triple_50", 32'(out_cnt), 32'd50);
    @(posedge clk); #1;
    rst_s = 1'b0;
    @(posedge clk); #1;
    rst_s = 1'b1;
    #1;
    check("rst_addr_1", 32'(addr1_s), 32'd0);
    check("rst_addr_2", 32'(addr2_s), 32'd1);
    check("rst_addr_3", 32'(addr3_s), 32'd2);
    check("rst_out_valid", 32'(out_valid_s), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_rd_en", 32'(rd_en_s), 32'd0);
    @(posedge clk); #1;
    check("rst_late_valid", 32'(out_valid_s), 32'd0);
  endtask

  task automatic small_pass();
    int n_rd, n_out, d_at;
    n_rd = 0; n_out = 0; d_at = -1;
    start3_s = 1'b1;
    ready3_s = 1'b1;
    @(posedge clk); #1;
    start3_s = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (rd_en3_s) begin
        check("n3_addr_1", 32'(a31_s), 32'd0);
        check("n3_addr_2", 32'(a32_s), 32'd1);
        check("n3_addr_3", 32'(a33_s), 32'd2);
        n_rd++;
      end
      if (valid3_s && ready3_s) begin
        check("n3_data", 32'(data3_s), 32'({mem[2], mem[1], mem[0]}));
        n_out++;
      end
      if (done3_s && d_at < 0) d_at = c;
      @(posedge clk); #1;
    end
    check("n3_reads", 32'(n_rd), 32'd1);
    check("n3_triples", 32'(n_out), 32'd1);
    check("n3_done_cycle", 32'(d_at), 32'd3);
  endtask

  initial begin
    rst_s = 1'b0; start_s = 1'b1; out_ready_s = 1'b1;
    start3_s = 1'b0; ready3_s = 1'b1; cyc = 0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i % 256);
    build_exp();

    repeat (3) @(posedge clk);
    #1;
    check("reset_addr_1", 32'(addr1_s), 32'd0);
    check("reset_addr_2", 32'(addr2_s), 32'd1);
    check("reset_addr_3", 32'(addr3_s), 32'd2);
    check("reset_rd_en", 32'(rd_en_s), 32'd0);
    check("reset_out_valid", 32'(out_valid_s), 32'd0);
    check("reset_out_data", 32'(out_data_s), 32'd0);
    check("reset_busy", 32'(busy_s), 32'd0);
    check("reset_done", 32'(done_s), 32'd0);
    rst_s = 1'b1; start_s = 1'b0;
    @(posedge clk); #1;
    check("start_in_reset_ignored", 32'(busy_s), 32'd0);

    run_pass(0, 171);
    check("full_pass_first", 32'(exp_t[0]), 32'h020100);
    run_pass(1, 181);
    run_pass(3, 171);

    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    build_exp();
    run_pass(2, -1);
    run_pass(2, -1);

    reset_mid_pass();
    run_pass(0, 171);

    small_pass();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rstl_max_reader.md
RSTL_MAX_READER -- requirements
Module: rstl_max_reader

Interface
REQ-001 The block SHALL have parameter counterWidth, default 10, giving the width of the result-memory address.
REQ-002 The block SHALL have parameter numWeightRstlMax, default 507, giving the number of result-memory words to read; it must be a nonzero multiple of 3.
REQ-003 The block SHALL have parameter dataWidth, default 8, giving the width of one result-memory word.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have ports exactly as follows, clock and reset first:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a read pass.
- addr_1, addr_2, addr_3  out  counterWidth  result-memory read addresses, one per port.
- rd_en  out  1  read strobe for all three ports.
- rd_data_1, rd_data_2, rd_data_3  in  dataWidth  read data, valid exactly one cycle after rd_en.
- out_valid  out  1  output triple available.
- out_ready  in  1  downstream accepts the triple.
- out_data  out  3*dataWidth  packed output {rd_data_3, rd_data_2, rd_data_1}.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last triple is accepted.

Function
REQ-006 The block SHALL read triples in order; triple k uses addresses 3k, 3k+1, 3k+2 for k = 0 .. numWeightRstlMax/3-1.
REQ-007 After each rd_en, addr_1, addr_2 and addr_3 SHALL each advance by 3.
REQ-008 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN in the cycle rd_en is issued with addr_3 = numWeightRstlMax-1.
- DRAIN -> DONE when the buffer is empty, no read is in flight and no transfer is pending.
- DONE -> IDLE unconditionally after one cycle.
REQ-009 start SHALL be ignored in every state except IDLE.
REQ-010 In IDLE, the addresses SHALL hold 0, 1 and 2.
REQ-011 The block SHALL contain a 2-entry FIFO holding the packed triples.
REQ-012 rd_en SHALL be asserted only in RUN, and only when FIFO occupancy plus in-flight reads after this cycle's pop is less than 2; no triple is ever dropped.
REQ-013 Read data SHALL be written into the FIFO on the cycle after rd_en.
REQ-014 out_valid SHALL be high exactly when the FIFO is non-empty.
REQ-015 out_data SHALL equal the FIFO head, and 0 when the FIFO is empty.
REQ-016 A transfer SHALL occur when out_valid and out_ready are both high; it pops the head.
REQ-017 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-018 With out_ready held high, the block SHALL sustain one triple per cycle.
REQ-019 Latency SHALL be: the first rd_en in the cycle after start, and the first out_valid two cycles after start.
REQ-020 out_data and out_valid SHALL stay stable while out_valid is high and out_ready is low.
REQ-021 busy SHALL be high in RUN and DRAIN, and low in IDLE and DONE.
REQ-022 done SHALL be high only in DONE.
REQ-023 Addresses SHALL never exceed numWeightRstlMax-1 while rd_en is high; address wrap-around is not permitted.

Reset
REQ-024 With rst=0 at a clock edge, the block SHALL enter IDLE with these values:
- addr_1=0, addr_2=1, addr_3=2.
- rd_en=0, out_valid=0, out_data=0.
- busy=0, done=0.
- FIFO empty and in-flight flag cleared.
REQ-025 A reset mid-pass SHALL discard all buffered and in-flight data; data returning the cycle after reset SHALL be ignored.
REQ-026 start SHALL be ignored while rst=0.

Verification
REQ-027 Full pass: default parameters, memory word n = n mod 256, out_ready=1, start pulse -> 169 triples {2,1,0}, {5,4,3}, ..., last addresses 504/505/506; done pulses 171 cycles after start; busy low afterward.
REQ-028 Backpressure: out_ready=0 for 10 cycles after the first out_valid -> exactly 2 triples buffered, rd_en low, out_data stable at {2,1,0}; release -> triples resume in order with none lost or duplicated.
REQ-029 Random out_ready at 50% -> the output sequence equals the reference sequence, FIFO occupancy never exceeds 2, and rd_en is never high with addr_3 > 506.
REQ-030 start re-pulsed during RUN -> no effect; addresses continue monotonically and exactly one done pulse occurs.
REQ-031 rst=0 at triple 50 -> the next cycle shows addr 0/1/2, out_valid=0 and busy=0; a new start yields a full pass beginning at {2,1,0}.
REQ-032 numWeightRstlMax=3 -> a single rd_en at addresses 0/1/2, one triple out, and done 3 cycles after start when out_ready=1.
